seq_detect_ctrl: RTL and testbench

Run-time controller for the serial pattern-detection datapath.
- Holds a programmable pattern of 1..MAX_LEN bits and an overlap/non-overlap mode.
- Sequences each detection run (arm, run, complete), counts matches and signals completion after a programmed match target.
- Replaces hard-wired fixed-pattern detectors (e.g. 1010) where software must retarget the pattern without re-synthesis.

---
 rtl/seq_detect_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
//   Run-time controller for a serial pattern detector. It holds a
//   programmable pattern of 1..MAX_LEN bits, sequences each detection run
//   through IDLE -> RUN -> DONE, counts matches, and signals completion
//   after a programmed number of matches.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   cfg_we                config write strobe (accepted in IDLE only)
//   cfg_pattern           pattern; bit [len-1] is the first serial bit
//   cfg_len               pattern length, legal 1..MAX_LEN
//   cfg_overlap           1 = overlapping detection, 0 = non-overlapping
//   cfg_target            matches needed for done, 0 = run until abort
//   start, abort          run control (abort > start > data)
//   x, x_valid            serial data bit and its qualifier
//   busy                  high while in RUN
//   match                 registered one-cycle pulse per detected pattern
//   match_cnt             saturating match count of the current/last run
//   done                  level, high in DONE
//   err_cfg               one-cycle pulse when start is refused (bad len)
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               x,
  input  logic               x_valid,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               done,
  output logic               err_cfg
);

  localparam int FILL_W = $clog2(MAX_LEN + 1);
  localparam int CMP_W  = LEN_W + FILL_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  // Staged config is written by cfg_we; the active copy is taken at start,
  // so a write coinciding with start only affects the following run.
  logic [MAX_LEN-1:0]   pat_q, pat_d, act_pat_q, act_pat_d;
  logic [LEN_W-1:0]     len_q, len_d, act_len_q, act_len_d;
  logic                 ovl_q, ovl_d, act_ovl_q, act_ovl_d;
  logic [CNT_W-1:0]     tgt_q, tgt_d, act_tgt_q, act_tgt_d;
  logic [MAX_LEN-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 match_q, match_d;
  logic                 err_q, err_d;

  logic [MAX_LEN-1:0]   nxt;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 hit;
  logic                 launch;

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic len_ok(input logic [LEN_W-1:0] len);
    return (len != '0) && (int'(len) <= MAX_LEN);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    tgt_d     = tgt_q;
    act_pat_d = act_pat_q;
    act_len_d = act_len_q;
    act_ovl_d = act_ovl_q;
    act_tgt_d = act_tgt_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    match_d   = 1'b0;
    err_d     = 1'b0;

    nxt     = {hist_q[MAX_LEN-2:0], x};
    cnt_inc = sat_inc(cnt_q);
    // A hit needs enough bits since the run start (or since the last
    // non-overlapping hit) and the low len bits of the new history to agree.
    hit     = (state_q == RUN) && x_valid &&
              (CMP_W'(fill_q) + CMP_W'(1) >= CMP_W'(act_len_q)) &&
              (((nxt ^ act_pat_q) & len_mask(act_len_q)) == '0);
    launch  = 1'b0;

    if (state_q == IDLE && cfg_we) begin
      pat_d = cfg_pattern;
      len_d = cfg_len;
      ovl_d = cfg_overlap;
      tgt_d = cfg_target;
    end

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (len_ok(len_q)) launch = 1'b1;
            else               err_d  = 1'b1;
          end
        end
        RUN: begin
          if (x_valid) begin
            hist_d = nxt;
            fill_d = (fill_q == FILL_W'(MAX_LEN)) ? fill_q : fill_q + FILL_W'(1);
            if (hit) begin
              match_d = 1'b1;
              cnt_d   = cnt_inc;
              if (!act_ovl_q) fill_d = '0;
              if (act_tgt_q != '0 && cnt_inc == act_tgt_q) state_d = DONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (launch) begin
      state_d   = RUN;
      act_pat_d = pat_q;
      act_len_d = len_q;
      act_ovl_d = ovl_q;
      act_tgt_d = tgt_q;
      hist_d    = '0;
      fill_d    = '0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= LEN_W'(1);
      ovl_q     <= 1'b1;
      tgt_q     <= '0;
      act_pat_q <= '0;
      act_len_q <= LEN_W'(1);
      act_ovl_q <= 1'b1;
      act_tgt_q <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      match_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      tgt_q     <= tgt_d;
      act_pat_q <= act_pat_d;
      act_len_q <= act_len_d;
      act_ovl_q <= act_ovl_d;
      act_tgt_q <= act_tgt_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      err_q     <= err_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign err_cfg   = err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = 4'd1;
  logic       cfg_overlap = 1'b1;
  logic [7:0] cfg_target = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       busy, match, done, err_cfg;
  logic [7:0] match_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] mv;
  logic        m, gap_or;

  seq_detect_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .abort(abort), .x(x), .x_valid(x_valid),
    .busy(busy), .match(match), .match_cnt(match_cnt), .done(done),
    .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len,
                     input logic ov, input logic [7:0] tgt);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_target = tgt;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic feed(input logic b, output logic mo);
    x = b; x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    mo = match;
  endtask

  // Sends bits[n-1] first; mo[i] is the match seen after the i-th bit sent.
  task automatic feed_seq(input logic [15:0] bits, input int n, output logic [15:0] mo);
    logic mm;
    mo = '0;
    for (int i = 0; i < n; i++) begin
      feed(bits[n-1-i], mm);
      mo[i] = mm;
    end
  endtask

  task automatic gap();
    x = 1'b1; x_valid = 1'b0;
    tick();
    gap_or = gap_or | match;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_match", match, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_cfg, 0);
    chk("rst_cnt", match_cnt, 0);

    // Overlapping 1010
    cfg(8'b1010, 4'd4, 1'b1, 8'd0);
    do_start();
    chk("t1_busy_start", busy, 1);
    feed_seq(16'b110101010, 9, mv);
    chk("t1_matches", mv, 16'h0150);
    chk("t1_cnt", match_cnt, 3);
    chk("t1_busy", busy, 1);

    // abort and start together: abort wins, count retained
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_cnt", match_cnt, 3);

    // Non-overlapping
    cfg(8'b1010, 4'd4, 1'b0, 8'd0);
    do_start();
    chk("t2_cnt_clr", match_cnt, 0);
    feed_seq(16'b10101010, 8, mv);
    chk("t2_matches", mv, 16'h0088);
    chk("t2_cnt", match_cnt, 2);
    // config write in RUN must be ignored
    cfg(8'b0110, 4'd4, 1'b1, 8'd0);
    do_abort();
    do_start();
    feed_seq(16'b1010, 4, mv);
    chk("t5_cfg_ignored", mv, 16'h0008);
    chk("t5_cfg_cnt", match_cnt, 1);
    do_abort();

    // cfg_we together with start: run uses the old config (1010, non-overlap)
    cfg_pattern = 8'b11; cfg_len = 4'd2; cfg_overlap = 1'b1; cfg_target = 8'd0;
    cfg_we = 1'b1; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    chk("wst_busy", busy, 1);
    feed_seq(16'b11010, 5, mv);
    chk("wst_old_cfg", mv, 16'h0010);
    do_abort();
    do_start();
    feed_seq(16'b111, 3, mv);
    chk("wst_new_cfg", mv, 16'h0006);
    do_abort();

    // Target with gaps
    cfg(8'b1010, 4'd4, 1'b1, 8'd2);
    do_start();
    gap_or = 1'b0;
    mv = '0;
    for (int i = 0; i < 5; i++) begin
      feed(i[0] ? 1'b0 : 1'b1, m);
      mv[i] = m;
      gap();
    end
    chk("t3_first5", mv, 16'h0008);
    chk("t3_gap_nomatch", gap_or, 0);
    chk("t3_busy_mid", busy, 1);
    feed(1'b0, m);
    chk("t3_match2", m, 1);
    chk("t3_done", done, 1);
    chk("t3_busy_off", busy, 0);
    chk("t3_cnt", match_cnt, 2);
    feed_seq(16'b1010, 4, mv);
    chk("t3_done_ignores_x", mv, 16'h0000);
    chk("t3_done_hold", done, 1);
    chk("t3_cnt_hold", match_cnt, 2);
    do_start();
    chk("t3_restart_busy", busy, 1);
    chk("t3_restart_done", done, 0);
    chk("t3_restart_cnt", match_cnt, 0);
    do_abort();

    // Illegal lengths
    cfg(8'b1010, 4'd0, 1'b1, 8'd0);
    do_start();
    chk("t4_err0", err_cfg, 1);
    chk("t4_busy0", busy, 0);
    tick();
    chk("t4_err0_pulse", err_cfg, 0);
    cfg(8'b1010, 4'd9, 1'b1, 8'd0);
    do_start();
    chk("t4_err9", err_cfg, 1);
    chk("t4_busy9", busy, 0);
    tick();
    chk("t4_err9_pulse", err_cfg, 0);
    chk("t4_still_idle", busy, 0);

    // Reset mid-run
    cfg(8'b1010, 4'd4, 1'b1, 8'd0);
    do_start();
    feed_seq(16'b101, 3, mv);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_match", match, 0);
    chk("t6_done", done, 0);
    chk("t6_cnt", match_cnt, 0);
    // reset config is pattern 0, len 1: a single 0 matches
    do_start();
    feed(1'b0, m);
    chk("t6_default_cfg", m, 1);
    do_abort();
    cfg(8'b1010, 4'd4, 1'b1, 8'd0);
    do_start();
    feed(1'b0, m);
    chk("t6_no_spurious", m, 0);
    chk("t6_cnt0", match_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
